// File: rtl/fetch_unit.sv
// Instruction fetch: PC/IR registers with a 4-state request/ack handshake to instruction memory.
// Memory latency is arbitrary; timeout after TIMEOUT_CYCLES unacked REQ cycles; HLT or timeout halts until reset.
module fetch_unit #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPERAND_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES    = 8
) (
  input  logic                                   clock_in,
  input  logic                                   reset_in,
  input  logic                                   fetch_req_in,
  input  logic                                   pc_wr_in,
  input  logic                                   branch_in,
  output logic [OPERAND_WIDTH-1:0]               imem_addr_out,
  output logic                                   imem_req_out,
  input  logic                                   imem_ack_in,
  input  logic [INSTRUCTION_WIDTH-1:0]           imem_data_in,
  output logic [INSTRUCTION_WIDTH-OPERAND_WIDTH-1:0] op_code_out,
  output logic [OPERAND_WIDTH-1:0]               operand_out,
  output logic                                   ir_valid_out,
  output logic                                   halted_out,
  output logic                                   fetch_err_out
);

  localparam int OPC_W = INSTRUCTION_WIDTH - OPERAND_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_t;

  state_t                        state_q, state_d;
  logic [OPERAND_WIDTH-1:0]      pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          err_q, err_d;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fetch_req_in) state_d = S_REQ;
      end
      S_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (imem_ack_in) begin
          ir_d    = imem_data_in;
          cnt_d   = '0;
          state_d = S_VALID;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VALID: begin
        if (ir_q[INSTRUCTION_WIDTH-1:OPERAND_WIDTH] == '0) begin
          state_d = S_HALT;
        end else if (pc_wr_in) begin
          pc_d    = branch_in ? ir_q[OPERAND_WIDTH-1:0] : pc_q + OPERAND_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode flops only; no input-to-output combinational path.
  assign imem_addr_out = pc_q;
  assign imem_req_out  = (state_q == S_REQ);
  assign op_code_out   = ir_q[INSTRUCTION_WIDTH-1 -: OPC_W];
  assign operand_out   = ir_q[OPERAND_WIDTH-1:0];
  assign ir_valid_out  = (state_q == S_VALID);
  assign halted_out    = (state_q == S_HALT);
  assign fetch_err_out = err_q;

endmodule
